// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage and the stall control block:
// opcode classes, the NOP word and the fetch FSM state type.
package mips_pkg;

  localparam logic [5:0]  OP_HLT     = 6'b010001;
  localparam logic [5:0]  OP_LD      = 6'b010100;
  localparam logic [3:0]  OP_JMP_PFX = 4'b0111;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_JWAIT = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  function automatic logic is_ld(input logic [5:0] op);
    return op == OP_LD;
  endfunction

  function automatic logic is_hlt(input logic [5:0] op);
    return op == OP_HLT;
  endfunction

  function automatic logic is_jmp(input logic [5:0] op);
    return op[5:2] == OP_JMP_PFX;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: load has priority over increment, otherwise holds.
// Wraps modulo 2^PC_W; async active-low reset to RESET_PC.
module pc_reg #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ld_i,
  input  logic            inc_i,
  input  logic [PC_W-1:0] ld_val_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (ld_i) begin
      pc_d = ld_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch: owns the PC and IF/ID register, reacts to load-use, jump
// and halt stalls, and flags protocol errors (unknown-op stall, stall_pm skew).
module fetch_ctrl
  import mips_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             stall_pm,
  input  logic [31:0]      pm_data,
  output logic [PC_W-1:0]  pm_addr,
  output logic             pm_en,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [5:0]       op,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             err
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_prev_q;
  logic             chk_en_q;

  logic             pc_ld, pc_inc;
  logic [PC_W-1:0]  pc;
  logic [5:0]       cur_op;

  assign cur_op = instr_q[31:26];

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i    (clk),
    .rst_ni   (reset),
    .ld_i     (pc_ld),
    .inc_i    (pc_inc),
    .ld_val_i (instr_q[PC_W-1:0]),
    .pc_o     (pc)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    valid_d  = 1'b0;
    halted_d = halted_q;
    err_d    = err_q;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (!stall) begin
          pc_inc  = 1'b1;
          instr_d = pm_data;
          valid_d = 1'b1;
        end else if (is_jmp(cur_op)) begin
          // instr keeps the jump so the stall block still sees it in JWAIT
          pc_ld   = 1'b1;
          state_d = ST_JWAIT;
        end else if (is_hlt(cur_op)) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else if (!is_ld(cur_op)) begin
          err_d = 1'b1;
        end
      end
      ST_JWAIT: begin
        if (!stall) begin
          pc_inc  = 1'b1;
          instr_d = pm_data;
          valid_d = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
      end
      default: state_d = ST_RUN;
    endcase

    if ((state_q != ST_HALT) && chk_en_q && (stall_pm != stall_prev_q)) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      instr_q      <= NOP;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      stall_prev_q <= 1'b0;
      chk_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      halted_q     <= halted_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      stall_prev_q <= stall;
      chk_en_q     <= 1'b1;
    end
  end

  assign pm_addr     = pc;
  assign pm_en       = ~stall & (state_q != ST_HALT);
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign op          = cur_op;
  assign halted      = halted_q;
  assign stall_cnt   = cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a behavioural fetch model predicts the
// registered outputs after every edge; a monitor pops and compares them.
module tb_fetch_ctrl;

  localparam int PC_W  = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             stall = 1'b0;
  logic             stall_pm = 1'b0;
  logic [31:0]      pm_data;
  logic [PC_W-1:0]  pm_addr;
  logic             pm_en;
  logic [31:0]      instr;
  logic             instr_valid;
  logic [5:0]       op;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic             err;

  logic [31:0] mem [256];
  assign pm_data = mem[pm_addr];

  always #5 clk = ~clk;

  fetch_ctrl #(
    .PC_W     (PC_W),
    .RESET_PC (8'h00),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .stall_pm    (stall_pm),
    .pm_data     (pm_data),
    .pm_addr     (pm_addr),
    .pm_en       (pm_en),
    .instr       (instr),
    .instr_valid (instr_valid),
    .op          (op),
    .halted      (halted),
    .stall_cnt   (stall_cnt),
    .err         (err)
  );

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
    logic        err;
    logic [3:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = fetching, 1 = waiting for jump target, 2 = halted
  int          m_pc, m_cnt, m_mode;
  logic [31:0] m_instr;
  bit          m_valid, m_halted, m_err, m_prev, m_chk;
  int          jw_cycles;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 0; m_cnt = 0; m_mode = 0; m_instr = 32'h0;
    m_valid = 0; m_halted = 0; m_err = 0; m_prev = 0; m_chk = 0;
    jw_cycles = 0;
  endfunction

  function automatic void model_step(input bit st, input bit spm);
    logic [5:0] o;
    bit nv;
    o  = m_instr[31:26];
    nv = 0;
    if (m_mode != 2 && m_chk && spm != m_prev) m_err = 1;
    if (st && m_cnt < 15) m_cnt++;
    if (m_mode == 0) begin
      if (!st) begin
        m_instr = mem[m_pc]; m_pc = (m_pc + 1) % 256; nv = 1;
      end else if (o[5:2] == 4'b0111) begin
        m_pc = int'(m_instr[7:0]); m_mode = 1;
      end else if (o == 6'b010001) begin
        m_halted = 1; m_mode = 2;
      end else if (o != 6'b010100) begin
        m_err = 1;
      end
    end else if (m_mode == 1) begin
      if (!st) begin
        m_instr = mem[m_pc]; m_pc = (m_pc + 1) % 256; nv = 1; m_mode = 0;
      end
    end
    m_valid = nv;
    m_prev  = st;
    m_chk   = 1;
  endfunction

  // Starts and ends at a falling edge; the rising edge in between is checked by the monitor.
  task automatic cycle(input bit st, input bit spm);
    exp_t e;
    bit exp_en;
    stall = st; stall_pm = spm;
    exp_en = !st && (m_mode != 2);
    model_step(st, spm);
    e.pc = 8'(m_pc); e.instr = m_instr; e.valid = m_valid;
    e.halted = m_halted; e.err = m_err; e.cnt = 4'(m_cnt);
    sb.push_back(e);
    #1;
    chk("pm_en", {63'd0, pm_en}, {63'd0, exp_en});
    @(negedge clk);
  endtask

  // Acts as the stall control block: LD/JMP/HLT stall once valid, JMP holds one more cycle.
  task automatic run_auto(input int n, input bit chaos);
    bit st, spm;
    logic [5:0] o;
    for (int i = 0; i < n; i++) begin
      o = m_instr[31:26];
      if (m_mode == 2) begin
        st = bit'($urandom_range(0, 1));
      end else if (m_mode == 1) begin
        st = (jw_cycles == 0);
        jw_cycles++;
      end else begin
        jw_cycles = 0;
        st = m_valid && (o == 6'b010100 || o[5:2] == 4'b0111 || o == 6'b010001);
      end
      if (chaos && $urandom_range(0, 3) == 0) st = bit'($urandom_range(0, 1));
      spm = m_prev;
      if (chaos && $urandom_range(0, 39) == 0) spm = !spm;
      cycle(st, spm);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".pm_addr"}, 64'(pm_addr), 64'd0);
    chk({tag, ".instr"}, 64'(instr), 64'd0);
    chk({tag, ".valid"}, 64'(instr_valid), 64'd0);
    chk({tag, ".op"}, 64'(op), 64'd0);
    chk({tag, ".halted"}, 64'(halted), 64'd0);
    chk({tag, ".err"}, 64'(err), 64'd0);
    chk({tag, ".cnt"}, 64'(stall_cnt), 64'd0);
    chk({tag, ".pm_en"}, 64'(pm_en), 64'd1);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0; stall = 1'b0; stall_pm = 1'b0;
    #1;
    check_reset_vals(tag);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  function automatic logic [31:0] rand_word(input bit allow_hlt);
    int r;
    logic [31:0] w;
    r = $urandom_range(0, 39);
    w = $urandom;
    if (r < 4) w[31:26] = 6'b010100;
    else if (r < 8) w[31:26] = {4'b0111, 2'($urandom_range(0, 3))};
    else if (r == 8 && allow_hlt) w[31:26] = 6'b010001;
    else if (r < 30) w[31:26] = 6'b000000;
    return w;
  endfunction

  task automatic fill_linear();
    for (int a = 0; a < 256; a++) mem[a] = {24'h0, 8'(a)};
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pm_addr", 64'(pm_addr), 64'(e.pc));
        chk("instr", 64'(instr), 64'(e.instr));
        chk("instr_valid", 64'(instr_valid), 64'(e.valid));
        chk("op", 64'(op), 64'(e.instr[31:26]));
        chk("halted", 64'(halted), 64'(e.halted));
        chk("err", 64'(err), 64'(e.err));
        chk("stall_cnt", 64'(stall_cnt), 64'(e.cnt));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks %0d errors", checks, errors);
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    model_reset();
    @(negedge clk);

    // Straight-line fetch with PC wrap
    fill_linear();
    do_reset("rst0");
    run_auto(270, 0);

    // Load-use at 4, jump to 0x40 at 7, halt at 0x43, then async reset mid-cycle
    fill_linear();
    mem[4]    = {6'b010100, 26'h0};
    mem[7]    = {6'b011100, 18'h0, 8'h40};
    mem[8'h43] = {6'b010001, 26'h0};
    do_reset("rst1");
    run_auto(60, 0);
    @(posedge clk);
    #2;
    reset = 1'b0; stall = 1'b0; stall_pm = 1'b0;
    #1;
    check_reset_vals("async");
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // Halt at address 3, PC frozen at 4
    fill_linear();
    mem[3] = {6'b010001, 26'h0};
    run_auto(30, 0);

    // Unknown-op stall, stall_pm skew, counter saturation
    fill_linear();
    do_reset("rst2");
    cycle(1, 0);
    cycle(1, m_prev);
    cycle(0, 0);
    cycle(0, m_prev);
    for (int i = 0; i < 21; i++) cycle(1, m_prev);
    chk("cnt_sat", 64'(stall_cnt), 64'd15);
    chk("err_sticky", 64'(err), 64'd1);

    // Randomised programs, alternating well-behaved and erratic stall sources
    for (int p = 0; p < 8; p++) begin
      for (int a = 0; a < 256; a++) mem[a] = rand_word(p % 3 == 2);
      do_reset("rstr");
      run_auto(300, p % 2 == 1);
    end

    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
